// File: rtl/branch_stack_if.sv
// Branch stack bus: dispatch allocation, branch FU resolution, and the
// registered broadcast/restore outputs. Task encoding (2 bits):
// 0 = NOTHING, 1 = CLEAR, 2 = SQUASH.
interface branch_stack_if #(
   parameter int DEPTH  = 4,
   parameter int CP_W   = 64,
   parameter int ADDR_W = 32
);
   logic              alloc_req;
   logic [CP_W-1:0]   alloc_cp;
   logic              alloc_gnt;
   logic [DEPTH-1:0]  alloc_b_id;
   logic [DEPTH-1:0]  cur_b_mask;
   logic              full;
   logic              res_valid;
   logic [1:0]        res_task;
   logic [DEPTH-1:0]  res_b_id;
   logic [ADDR_W-1:0] res_target;
   logic [1:0]        rem_br_task;
   logic [DEPTH-1:0]  rem_b_id;
   logic              restore_valid;
   logic [CP_W-1:0]   restore_cp;
   logic [ADDR_W-1:0] redirect_pc;

   modport master (
      output alloc_req, alloc_cp, res_valid, res_task, res_b_id, res_target,
      input  alloc_gnt, alloc_b_id, cur_b_mask, full,
             rem_br_task, rem_b_id, restore_valid, restore_cp, redirect_pc
   );

   modport slave (
      input  alloc_req, alloc_cp, res_valid, res_task, res_b_id, res_target,
      output alloc_gnt, alloc_b_id, cur_b_mask, full,
             rem_br_task, rem_b_id, restore_valid, restore_cp, redirect_pc
   );
endinterface

// File: rtl/branch_stack.sv
// Branch checkpoint stack: one-hot branch ID allocation, per-branch recovery
// checkpoint, and the registered CLEAR/SQUASH broadcast to the back end.
module branch_stack #(
   parameter int DEPTH  = 4,
   parameter int CP_W   = 64,
   parameter int ADDR_W = 32
) (
   input logic          clock,
   input logic          reset,
   branch_stack_if.slave bus
);
   localparam logic [1:0] BR_NOTHING = 2'd0;
   localparam logic [1:0] BR_CLEAR   = 2'd1;
   localparam logic [1:0] BR_SQUASH  = 2'd2;

   logic [DEPTH-1:0] valid;
   logic [CP_W-1:0]  cp  [DEPTH];
   logic [DEPTH-1:0] dep [DEPTH];

   logic             one_hot, live, clear_acc, squash_acc, gnt;
   logic [DEPTH-1:0] clear_bits, grant_id, kill_mask;
   logic [CP_W-1:0]  sel_cp;

   // Resolution acceptance: only well-formed requests against a live slot count.
   always_comb begin
      one_hot    = (bus.res_b_id != '0) && ((bus.res_b_id & (bus.res_b_id - DEPTH'(1))) == '0);
      live       = |(bus.res_b_id & valid);
      clear_acc  = bus.res_valid && (bus.res_task == BR_CLEAR)  && one_hot && live;
      squash_acc = bus.res_valid && (bus.res_task == BR_SQUASH) && one_hot && live;
      clear_bits = clear_acc ? bus.res_b_id : '0;
   end

   // Lowest free slot, kill set for the resolving branch, and checkpoint read-out.
   always_comb begin
      grant_id  = '0;
      kill_mask = '0;
      sel_cp    = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid[i]) grant_id = DEPTH'(1) << i;
      end
      for (int i = 0; i < DEPTH; i++) begin
         // SQUASH also drops every younger branch, i.e. those that recorded this ID in dep.
         kill_mask[i] = (clear_acc  && bus.res_b_id[i]) ||
                        (squash_acc && (bus.res_b_id[i] || |(dep[i] & bus.res_b_id)));
         if (bus.res_b_id[i]) sel_cp = sel_cp | cp[i];
      end
   end

   // Allocation handshake; a squash in flight flushes the front end, so no grant.
   always_comb begin
      bus.full       = &valid;
      bus.cur_b_mask = valid;
      gnt            = bus.alloc_req && !bus.full && !squash_acc;
      bus.alloc_gnt  = gnt;
      bus.alloc_b_id = gnt ? grant_id : '0;
   end

   // Slot state; a slot freed this cycle is not in grant_id, so it reopens at N+1.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            cp[i]  <= '0;
            dep[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (gnt && grant_id[i]) begin
               valid[i] <= 1'b1;
               cp[i]    <= bus.alloc_cp;
               dep[i]   <= valid & ~clear_bits;
            end else begin
               if (kill_mask[i]) valid[i] <= 1'b0;
               dep[i] <= dep[i] & ~clear_bits;
            end
         end
      end
   end

   // One-cycle broadcast of the accepted resolution plus restore data on SQUASH.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.rem_br_task   <= BR_NOTHING;
         bus.rem_b_id      <= '0;
         bus.restore_valid <= 1'b0;
         bus.restore_cp    <= '0;
         bus.redirect_pc   <= '0;
      end else begin
         bus.rem_br_task   <= (clear_acc || squash_acc) ? bus.res_task : BR_NOTHING;
         bus.rem_b_id      <= (clear_acc || squash_acc) ? bus.res_b_id : '0;
         bus.restore_valid <= squash_acc;
         if (squash_acc) begin
            bus.restore_cp  <= sel_cp;
            bus.redirect_pc <= bus.res_target;
         end
      end
   end
endmodule
